// File: rtl/max_pool.sv
// max_pool: 2x2 stride-2 max pooling over a pixel stream with frame/row markers.
// Optional macro MAX_POOL_BINARIZE_EN thresholds the pooled max against THRESHOLD.
module max_pool #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540,
    parameter int THRESHOLD = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eol
);
    localparam int CW = $clog2(ROW_SIZE);
    localparam int HW = ROW_SIZE / 2;
    localparam int IW = HW > 1 ? $clog2(HW) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] EOLC = CW'((ROW_SIZE % 2 == 0) ? ROW_SIZE - 1 : ROW_SIZE - 2);

    logic [CW-1:0]        col, ecol;
    logic                 row, erow, sof_pend;
    logic [IW-1:0]        idx;
    logic [WORD_SIZE-1:0] hold, pair, lb_rd, pooled, result;
    logic [WORD_SIZE-1:0] linebuf [HW];

    // in_sof forces position to the frame origin; pair/block maxima are unsigned
    always_comb begin
        ecol   = in_sof ? '0 : col;
        erow   = in_sof ? 1'b0 : row;
        idx    = IW'(ecol >> 1);
        pair   = hold > inputPixel ? hold : inputPixel;
        lb_rd  = linebuf[idx];
        pooled = lb_rd > pair ? lb_rd : pair;
`ifdef MAX_POOL_BINARIZE_EN
        result = pooled >= WORD_SIZE'(THRESHOLD) ? '1 : '0;
`else
        result = pooled;
`endif
    end

    // position counters, horizontal hold and registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= 1'b0;
            hold        <= '0;
            sof_pend    <= 1'b0;
            outputPixel <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            if (in_valid) begin
                col <= ecol == LAST ? '0 : ecol + 1'b1;
                row <= ecol == LAST ? ~erow : erow;
                if (in_sof) sof_pend <= 1'b1;
                if (!ecol[0]) hold <= inputPixel;
                else if (erow) begin
                    outputPixel <= result;
                    out_valid   <= 1'b1;
                    out_sof     <= sof_pend;
                    out_eol     <= ecol == EOLC;
                    sof_pend    <= 1'b0;
                end
            end
        end
    end

    // even-row pair maxima, always written before the odd row reads them
    always_ff @(posedge clk) begin
        if (!rst && in_valid && ecol[0] && !erow) linebuf[idx] <= pair;
    end
endmodule

// File: tb/tb_max_pool.sv
// tb_max_pool: randomized and directed checks of max_pool (ROW_SIZE 4 and 5) against a frame-array model.
module tb_max_pool;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix = '0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] op [2];
    logic       ov [2];
    logic       os [2];
    logic       oe [2];

    max_pool #(.WORD_SIZE(8), .ROW_SIZE(4), .THRESHOLD(128)) d4 (
        .clk(clk), .rst(rst), .inputPixel(pix), .in_valid(in_valid), .in_sof(in_sof),
        .outputPixel(op[0]), .out_valid(ov[0]), .out_sof(os[0]), .out_eol(oe[0]));
    max_pool #(.WORD_SIZE(8), .ROW_SIZE(5), .THRESHOLD(128)) d5 (
        .clk(clk), .rst(rst), .inputPixel(pix), .in_valid(in_valid), .in_sof(in_sof),
        .outputPixel(op[1]), .out_valid(ov[1]), .out_sof(os[1]), .out_eol(oe[1]));

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] frm [2][$];
    bit         pend [2];
    logic [7:0] lastp [2];
    bit         ev [2], es [2], ee [2];
    logic [7:0] got4 [$];

    function automatic logic [7:0] bin(logic [7:0] m);
`ifdef MAX_POOL_BINARIZE_EN
        return m >= 8'd128 ? 8'hFF : 8'h00;
`else
        return m;
`endif
    endfunction

    function automatic logic [7:0] mx(logic [7:0] a, logic [7:0] b);
        return a > b ? a : b;
    endfunction

    task automatic chk(string tag, int k, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s rs=%0d got=%0h exp=%0h", tag, k + 4, got, exp);
        end
    endtask

    // pixels since the last sof/reset are kept whole; an output is due at each
    // odd column of an odd row, the max of the 2x2 block ending at that pixel
    task automatic model(int k, int rs);
        int n, r, c, lastc;
        ev[k] = 0; es[k] = 0; ee[k] = 0;
        if (rst) begin
            frm[k].delete();
            pend[k] = 0;
            lastp[k] = '0;
            return;
        end
        if (!in_valid) return;
        if (in_sof) begin
            frm[k].delete();
            pend[k] = 1;
        end
        frm[k].push_back(pix);
        n = frm[k].size() - 1;
        r = n / rs;
        c = n % rs;
        lastc = (rs % 2 == 0) ? rs - 1 : rs - 2;
        if (r % 2 == 1 && c % 2 == 1) begin
            lastp[k] = bin(mx(mx(frm[k][(r-1)*rs + c - 1], frm[k][(r-1)*rs + c]),
                              mx(frm[k][n-1], frm[k][n])));
            ev[k] = 1;
            es[k] = pend[k];
            pend[k] = 0;
            ee[k] = (c == lastc);
        end
    endtask

    task automatic step(logic r, logic v, logic s, logic [7:0] p);
        rst = r; in_valid = v; in_sof = s; pix = p;
        @(posedge clk);
        model(0, 4);
        model(1, 5);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("valid", k, 8'(ov[k]), 8'(ev[k]));
            chk("sof",   k, 8'(os[k]), 8'(es[k]));
            chk("eol",   k, 8'(oe[k]), 8'(ee[k]));
            chk("pixel", k, op[k], lastp[k]);
        end
        if (ov[0]) got4.push_back(op[0]);
    endtask

    task automatic send(logic s, logic [7:0] p);
        step(1'b0, 1'b1, s, p);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    int rowa [8] = '{1, 9, 3, 2, 4, 0, 7, 8};
    int r5 [10] = '{1, 2, 3, 4, 200, 0, 0, 0, 0, 0};

    initial begin
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd77);
        // two rows streamed back to back
        got4.delete();
        for (int i = 0; i < 8; i++) send(i == 0, 8'(rowa[i]));
        bubble();
        chk("seq_count", 0, 8'(got4.size()), 8'd2);
        if (got4.size() == 2) begin
            chk("seq_first", 0, got4[0], bin(8'd9));
            chk("seq_second", 0, got4[1], bin(8'd8));
        end
        // same rows with bubbles between every pixel
        for (int i = 0; i < 8; i++) begin
            send(i == 0, 8'(rowa[i]));
            bubble();
        end
        // second sof mid-row 1
        for (int i = 0; i < 6; i++) send(i == 0, 8'($urandom));
        for (int i = 0; i < 10; i++) send(i == 0, 8'($urandom));
        // reset after row 0 plus 2 pixels, then constant rows
        for (int i = 0; i < 6; i++) send(i == 0, 8'(250 - i));
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) send(1'b0, i < 4 ? 8'd5 : 8'd6);
        // odd row length, last column discarded
        for (int i = 0; i < 10; i++) send(i == 0, 8'(r5[i]));
        // threshold boundary maxima 127 and 128
        for (int i = 0; i < 8; i++) send(i == 0, i == 1 ? 8'd127 : (i == 6 ? 8'd128 : 8'd0));
        // random traffic with occasional sof and reset
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0, 8'($urandom));
        bubble();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
